// File: rtl/vdp_cpu_port_pkg.sv
// Shared constants for the VDP CPU port: access codes, register count and reset image,
// prefetch FSM states and status bit positions.
package vdp_cpu_port_pkg;

   localparam int unsigned NUM_REGS = 11;
   localparam int unsigned ADDR_W   = 14;
   localparam int unsigned CRAM_W   = 6;

   typedef enum logic [1:0] {
      CodeVrd  = 2'd0,
      CodeVwr  = 2'd1,
      CodeReg  = 2'd2,
      CodeCram = 2'd3
   } code_e;

   typedef enum logic [1:0] {
      StIdle,
      StRdAddr,
      StRdWait,
      StRdCap
   } pf_state_e;

   // Status bits [6:5] are sprite flags and read as zero until a sprite engine exists.
   localparam int unsigned STAT_FRAME = 7;

   // Interrupt enables: r1[5] gates the frame interrupt, r0[4] the line interrupt.
   localparam int unsigned IE_FRAME_BIT = 8 + 5;
   localparam int unsigned IE_LINE_BIT  = 4;

   // {r10..r0}
   localparam logic [NUM_REGS*8-1:0] REG_RESET = {
      8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hE2, 8'h26
   };

endpackage

// File: rtl/vdp_reg_file.sv
// VDP register file: NUM_REGS x 8 bits with a single write port and a flattened read-out.
module vdp_reg_file
   import vdp_cpu_port_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_we,
   input  logic [3:0]            i_idx,
   input  logic [7:0]            i_wdata,
   output logic [NUM_REGS*8-1:0] o_regs
);

   logic [7:0] r_regs [NUM_REGS];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= REG_RESET[i*8 +: 8];
         end
      end else if (i_we && (32'(i_idx) < NUM_REGS)) begin
         r_regs[i_idx] <= i_wdata;
      end
   end

   always_comb begin
      o_regs = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         o_regs[i*8 +: 8] = r_regs[i];
      end
   end

endmodule

// File: rtl/vdp_cpu_port.sv
// Z80 side of the VDP: decodes control/data port strobes into VRAM/CRAM/register writes,
// runs the VRAM read prefetch, and owns the status register and /INT.
module vdp_cpu_port
   import vdp_cpu_port_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_ctrl_wr,
   input  logic                  i_ctrl_rd,
   input  logic                  i_data_wr,
   input  logic                  i_data_rd,
   input  logic [7:0]            i_cpu_di,
   output logic [7:0]            o_cpu_do,
   output logic                  o_busy,
   output logic                  o_drop,
   output logic [ADDR_W-1:0]     o_vram_addr,
   output logic [7:0]            o_vram_di,
   output logic                  o_vram_we,
   input  logic [7:0]            i_vram_do,
   output logic [CRAM_W-1:0]     o_cram_addr,
   output logic [7:0]            o_cram_di,
   output logic                  o_cram_we,
   output logic [NUM_REGS*8-1:0] o_regs,
   input  logic                  i_frame_int,
   input  logic                  i_line_int,
   output logic                  o_irq_n
);

   pf_state_e             r_state, w_state_d;
   code_e                 r_code;
   logic [ADDR_W-1:0]     r_addr, r_wr_addr;
   logic [7:0]            r_rbuf, r_cpu_do, r_vram_di, r_cram_di;
   logic [CRAM_W-1:0]     r_cram_addr;
   logic                  r_second, r_frame, r_line_pend, r_irq_n, r_drop, r_vram_we, r_cram_we;
   logic                  w_busy, w_acc_cw, w_acc_dw, w_acc_dr, w_acc_cr, w_drop;
   logic                  w_pf_start, w_reg_we, w_frame_d, w_line_d;
   logic [7:0]            w_status;
   logic [NUM_REGS*8-1:0] w_regs;

   always_comb begin
      w_busy   = (r_state != StIdle);
      w_acc_cw = ~w_busy & i_ctrl_wr;
      w_acc_dw = ~w_busy & i_data_wr & ~i_ctrl_wr;
      w_acc_dr = ~w_busy & i_data_rd & ~i_ctrl_wr & ~i_data_wr;
      w_acc_cr = ~w_busy & i_ctrl_rd & ~i_ctrl_wr & ~i_data_wr & ~i_data_rd;
      // Busy drops everything; otherwise every strobe below the winner is dropped.
      if (w_busy) begin
         w_drop = i_ctrl_wr | i_data_wr | i_data_rd | i_ctrl_rd;
      end else begin
         w_drop = (i_ctrl_wr & (i_data_wr | i_data_rd | i_ctrl_rd))
                | (i_data_wr & (i_data_rd | i_ctrl_rd))
                | (i_data_rd & i_ctrl_rd);
      end
      w_pf_start = (w_acc_cw & r_second & (code_e'(i_cpu_di[7:6]) == CodeVrd)) | w_acc_dr;
      w_reg_we   = w_acc_cw & r_second & (code_e'(i_cpu_di[7:6]) == CodeReg);
      // A new interrupt wins over a clearing status read in the same cycle.
      w_frame_d  = (r_frame & ~w_acc_cr) | i_frame_int;
      w_line_d   = (r_line_pend & ~w_acc_cr) | i_line_int;
      w_status             = '0;
      w_status[STAT_FRAME] = r_frame;
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle:   if (w_pf_start) w_state_d = StRdAddr;
         StRdAddr: w_state_d = StRdWait;
         StRdWait: w_state_d = StRdCap;
         StRdCap:  w_state_d = StIdle;
         default:  w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_code      <= CodeVrd;
         r_addr      <= '0;
         r_wr_addr   <= '0;
         r_second    <= 1'b0;
         r_rbuf      <= '0;
         r_cpu_do    <= '0;
         r_vram_di   <= '0;
         r_vram_we   <= 1'b0;
         r_cram_addr <= '0;
         r_cram_di   <= '0;
         r_cram_we   <= 1'b0;
         r_drop      <= 1'b0;
         r_frame     <= 1'b0;
         r_line_pend <= 1'b0;
         r_irq_n     <= 1'b1;
      end else begin
         r_vram_we   <= 1'b0;
         r_cram_we   <= 1'b0;
         r_drop      <= w_drop;
         r_frame     <= w_frame_d;
         r_line_pend <= w_line_d;
         r_irq_n     <= ~((w_frame_d & w_regs[IE_FRAME_BIT]) | (w_line_d & w_regs[IE_LINE_BIT]));
         if (w_acc_cw) begin
            if (!r_second) begin
               r_addr[7:0] <= i_cpu_di;
               r_second    <= 1'b1;
            end else begin
               r_code              <= code_e'(i_cpu_di[7:6]);
               r_addr[ADDR_W-1:8]  <= i_cpu_di[5:0];
               r_second            <= 1'b0;
            end
         end else if (w_acc_dw) begin
            r_second <= 1'b0;
            r_rbuf   <= i_cpu_di;
            if (r_code == CodeCram) begin
               r_cram_we   <= 1'b1;
               r_cram_addr <= r_addr[CRAM_W-1:0];
               r_cram_di   <= i_cpu_di;
            end else begin
               r_vram_we <= 1'b1;
               r_wr_addr <= r_addr;
               r_vram_di <= i_cpu_di;
            end
            r_addr <= r_addr + 14'd1;
         end else if (w_acc_dr) begin
            r_second <= 1'b0;
            r_cpu_do <= r_rbuf;
         end else if (w_acc_cr) begin
            r_second <= 1'b0;
            r_cpu_do <= w_status;
         end
         if (r_state == StRdCap) begin
            r_rbuf <= i_vram_do;
            r_addr <= r_addr + 14'd1;
         end
      end
   end

   vdp_reg_file u_reg_file (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (w_reg_we),
      .i_idx   (i_cpu_di[3:0]),
      .i_wdata (r_addr[7:0]),
      .o_regs  (w_regs)
   );

   // The read address is held for the whole prefetch so i_vram_do stays valid into StRdCap.
   assign o_vram_addr = w_busy ? r_addr : r_wr_addr;
   assign o_vram_di   = r_vram_di;
   assign o_vram_we   = r_vram_we;
   assign o_cram_addr = r_cram_addr;
   assign o_cram_di   = r_cram_di;
   assign o_cram_we   = r_cram_we;
   assign o_cpu_do    = r_cpu_do;
   assign o_busy      = w_busy;
   assign o_drop      = r_drop;
   assign o_irq_n     = r_irq_n;
   assign o_regs      = w_regs;

endmodule
